cross_bar_switch: RTL and testbench

//  Buffered N-in/M-out crossbar routing words by a destination field inside each word.

---
 rtl/xbar_pkg.sv | 18 +
 rtl/xbar_fifo.sv | 59 +++++
 rtl/cross_bar_switch.sv | 122 ++++++++++++
 tb/tb_cross_bar_switch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/xbar_pkg.sv
// Shared constants and helpers for the buffered crossbar switch.
package xbar_pkg;

    // Ceiling log2 for sizing counters and pointers from elaboration-time values.
    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value)
            r = r + 1;
        return r;
    endfunction

    // Ports are packed with port 0 in the most significant slice of the bus.
    function automatic int port_lsb(input int port, input int ports, input int width);
        return (ports - 1 - port) * width;
    endfunction

endpackage

// File: rtl/xbar_fifo.sv
// Synchronous input FIFO with a combinational head word and registered occupancy flags.
module xbar_fifo
    import xbar_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 32,
    parameter int AF_MARGIN  = 2,
    localparam int PTR_W     = log2(FIFO_DEPTH),
    localparam int CNT_W     = log2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             almost_full
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count, so a push while full is dropped even if a pop happens.
    assign full        = (count == CNT_W'(FIFO_DEPTH));
    assign almost_full = (count >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
    assign push_ok     = push && !full;
    assign pop_ok      = pop && (count != '0);
    assign head        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define validity, so a flush is just a pointer reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cross_bar_switch.sv
// Buffered N-in/M-out crossbar: one FIFO per input, one round-robin arbiter and output register per output.
// Define XBAR_OVERFLOW_CHECK_EN for a simulation-only message on every push into a full input FIFO.
module cross_bar_switch
    import xbar_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int IN_PORTS       = 8,
    parameter int OUT_PORTS      = 8,
    parameter int FIFO_DEPTH     = 32,
    parameter int IN_ADDR_WIDTH  = 3,
    parameter int OUT_ADDR_WIDTH = 3,
    parameter int SEL_LSB        = 0,
    parameter int AF_MARGIN      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [0:IN_PORTS-1]            valid_in,
    input  logic [IN_PORTS*WIDTH-1:0]      data_in,
    output logic [0:IN_PORTS-1]            full,
    output logic [0:OUT_PORTS-1]           valid_out,
    output logic [OUT_PORTS*WIDTH-1:0]     data_out,
    input  logic [OUT_PORTS-1:0]           stall,
    output logic [0:IN_PORTS-1]            almost_full
);

    localparam int CNT_W = log2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0]          head    [IN_PORTS];
    logic [OUT_ADDR_WIDTH-1:0] dest    [IN_PORTS];
    logic [IN_PORTS-1:0]       empty;
    logic [IN_PORTS-1:0]       discard;
    logic [IN_PORTS-1:0]       pop;
    logic [OUT_PORTS-1:0][IN_PORTS-1:0] grant;

    for (genvar i = 0; i < IN_PORTS; i++) begin : g_in
        logic [CNT_W-1:0] count;

        xbar_fifo #(
            .WIDTH      (WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .AF_MARGIN  (AF_MARGIN)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (valid_in[i]),
            .push_data   (data_in[port_lsb(i, IN_PORTS, WIDTH) +: WIDTH]),
            .pop         (pop[i]),
            .head        (head[i]),
            .count       (count),
            .full        (full[i]),
            .almost_full (almost_full[i])
        );

        assign empty[i]   = (count == '0);
        assign dest[i]    = head[i][SEL_LSB +: OUT_ADDR_WIDTH];
        // Heads addressed beyond the last output can never be granted, so drop them here.
        assign discard[i] = !empty[i] && (int'(dest[i]) >= OUT_PORTS);

`ifdef XBAR_OVERFLOW_CHECK_EN
        always @(posedge clk) begin
            if (!rst && valid_in[i] && full[i])
                $error("%0t %m: push to full input %0d dropped", $time, i);
        end
`endif
    end

    // Each head addresses exactly one output, so at most one grant per input and at most one pop.
    always_comb begin
        pop = discard;
        for (int i = 0; i < IN_PORTS; i++) begin
            for (int j = 0; j < OUT_PORTS; j++)
                pop[i] = pop[i] | grant[j][i];
        end
    end

    for (genvar j = 0; j < OUT_PORTS; j++) begin : g_out
        logic [IN_ADDR_WIDTH-1:0] rr;
        logic [IN_ADDR_WIDTH-1:0] gidx;
        logic                     found;
        logic [IN_PORTS-1:0]      req;
        logic                     valid_q;
        logic [WIDTH-1:0]         data_q;
        int                       idx;

        // NOTE: every combinational output gets a default before the search loop so no latch is inferred.
        always_comb begin
            req   = '0;
            found = 1'b0;
            gidx  = '0;
            idx   = 0;
            for (int i = 0; i < IN_PORTS; i++)
                req[i] = !empty[i] && (dest[i] == OUT_ADDR_WIDTH'(j)) && !stall[j];
            for (int k = 0; k < IN_PORTS; k++) begin
                idx = (int'(rr) + k) % IN_PORTS;
                if (!found && req[idx]) begin
                    found = 1'b1;
                    gidx  = IN_ADDR_WIDTH'(idx);
                end
            end
        end

        assign grant[j] = found ? (IN_PORTS'(1) << gidx) : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                rr      <= '0;
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (!stall[j]) begin
                valid_q <= found;
                if (found) begin
                    data_q <= head[gidx];
                    rr     <= (gidx == IN_ADDR_WIDTH'(IN_PORTS - 1)) ? '0 : gidx + IN_ADDR_WIDTH'(1);
                end
            end
        end

        assign valid_out[j]                                   = valid_q;
        assign data_out[port_lsb(j, OUT_PORTS, WIDTH) +: WIDTH] = data_q;
    end

endmodule

// File: tb/tb_cross_bar_switch.sv
// Directed bench for cross_bar_switch with 4x4 ports, 8-bit words and 4-deep FIFOs.
module tb_cross_bar_switch;

    localparam int W  = 8;
    localparam int NI = 4;
    localparam int NO = 4;

    logic              clk;
    logic              rst;
    logic [0:NI-1]     valid_in;
    logic [NI*W-1:0]   data_in;
    logic [0:NI-1]     full;
    logic [0:NO-1]     valid_out;
    logic [NO*W-1:0]   data_out;
    logic [NO-1:0]     stall;
    logic [0:NI-1]     almost_full;

    int checks;
    int errors;

    cross_bar_switch #(
        .WIDTH          (W),
        .IN_PORTS       (NI),
        .OUT_PORTS      (NO),
        .FIFO_DEPTH     (4),
        .IN_ADDR_WIDTH  (2),
        .OUT_ADDR_WIDTH (2),
        .SEL_LSB        (0),
        .AF_MARGIN      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .full        (full),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .stall       (stall),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [W-1:0] v);
        valid_in[i]              = 1'b1;
        data_in[(NI-1-i)*W +: W] = v;
    endtask

    function automatic logic [W-1:0] dout(input int j);
        return data_out[(NO-1-j)*W +: W];
    endfunction

    logic [W-1:0] s3_words [5];
    logic [W-1:0] s3_drain [3];
    logic [W-1:0] s2_exp   [3];

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        valid_in = '0;
        data_in  = '0;
        stall    = '0;
        s2_exp   = '{8'h01, 8'h11, 8'h31};
        s3_words = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
        s3_drain = '{8'h04, 8'h08, 8'h0C};

        repeat (2) step();
        rst = 1'b0;
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_full", 32'(full), 32'h0);
        check("rst_af", 32'(almost_full), 32'h0);

        // 1) single word, input 0 to output 2, one-cycle latency, one cycle wide
        drive(0, 8'h12);
        step();
        valid_in = '0;
        check("s1_not_yet", 32'(valid_out), 32'h0);
        step();
        check("s1_valid", 32'(valid_out), 32'b0010);
        check("s1_data", 32'(dout(2)), 32'h12);
        step();
        check("s1_gone", 32'(valid_out), 32'h0);

        // 2) three inputs contend for output 1, served in round-robin order
        drive(0, 8'h01);
        drive(1, 8'h11);
        drive(3, 8'h31);
        step();
        valid_in = '0;
        for (int n = 0; n < 3; n++) begin
            step();
            check("s2_valid", 32'(valid_out), 32'b0100);
            check("s2_data", 32'(dout(1)), 32'(s2_exp[n]));
        end
        step();
        check("s2_idle", 32'(valid_out), 32'h0);

        // 3) fill input 2 behind a stalled output 0; fifth push dropped
        stall = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            drive(2, s3_words[n]);
            step();
            check("s3_af", 32'(almost_full[2]), (n >= 2) ? 32'h1 : 32'h0);
            check("s3_full", 32'(full[2]), (n >= 3) ? 32'h1 : 32'h0);
        end
        check("s3_stalled", 32'(valid_out[0]), 32'h0);
        // push while full in the same cycle as the first pop: still dropped
        drive(2, 8'h14);
        stall = '0;
        step();
        valid_in = '0;
        check("s3_first_v", 32'(valid_out[0]), 32'h1);
        check("s3_first_d", 32'(dout(0)), 32'h00);
        check("s3_full_clr", 32'(full[2]), 32'h0);
        check("s3_af_hold", 32'(almost_full[2]), 32'h1);
        for (int n = 0; n < 3; n++) begin
            step();
            check("s3_drain_v", 32'(valid_out[0]), 32'h1);
            check("s3_drain_d", 32'(dout(0)), 32'(s3_drain[n]));
        end
        step();
        check("s3_dropped", 32'(valid_out[0]), 32'h0);
        check("s3_af_end", 32'(almost_full[2]), 32'h0);

        // 4) stall output 3 while it holds 0x23, then release for the queued 0x27
        drive(0, 8'h23);
        drive(1, 8'h27);
        step();
        valid_in = '0;
        step();
        check("s4_load_v", 32'(valid_out[3]), 32'h1);
        check("s4_load_d", 32'(dout(3)), 32'h23);
        stall = 4'b1000;
        repeat (3) begin
            step();
            check("s4_hold_v", 32'(valid_out[3]), 32'h1);
            check("s4_hold_d", 32'(dout(3)), 32'h23);
        end
        stall = '0;
        step();
        check("s4_next_v", 32'(valid_out[3]), 32'h1);
        check("s4_next_d", 32'(dout(3)), 32'h27);
        step();
        check("s4_idle", 32'(valid_out), 32'h0);

        // 5) reset with three words queued behind a stalled output 2
        stall = 4'b0100;
        drive(1, 8'h42);
        step();
        drive(1, 8'h46);
        step();
        drive(1, 8'h4A);
        step();
        valid_in = '0;
        check("s5_queued_af", 32'(almost_full[1]), 32'h1);
        rst = 1'b1;
        step();
        check("s5_rst_valid", 32'(valid_out), 32'h0);
        check("s5_rst_full", 32'(full), 32'h0);
        check("s5_rst_af", 32'(almost_full), 32'h0);
        check("s5_rst_data", data_out, 32'h0);
        rst   = 1'b0;
        stall = '0;
        repeat (5) begin
            step();
            check("s5_no_stale", 32'(valid_out), 32'h0);
        end

        // 6) every input to the next output at once: all four outputs fire together
        drive(0, 8'h51);
        drive(1, 8'h62);
        drive(2, 8'h73);
        drive(3, 8'h80);
        step();
        valid_in = '0;
        step();
        check("s6_valid", 32'(valid_out), 32'b1111);
        check("s6_out0", 32'(dout(0)), 32'h80);
        check("s6_out1", 32'(dout(1)), 32'h51);
        check("s6_out2", 32'(dout(2)), 32'h62);
        check("s6_out3", 32'(dout(3)), 32'h73);
        step();
        check("s6_idle", 32'(valid_out), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
